// File: rtl/dmem_port_arbiter_pkg.sv
// Shared sizing defaults, read-owner encoding and starvation-counter helper
// for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

  localparam int DEF_DBITS        = 32;
  localparam int DEF_ADDRBITS     = 32;
  localparam int DEF_DMEMADDRBITS = 16;
  localparam int DEF_DMEMWORDBITS = 2;
  localparam int DEF_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_P    = 2'd1,
    RD_H    = 2'd2
  } rd_owner_e;

  // A denied host request ages the counter up to the limit; anything else clears it.
  function automatic logic [3:0] starve_next(input logic [3:0] cnt,
                                             input logic       h_req,
                                             input logic       h_gnt,
                                             input logic [3:0] limit);
    logic [3:0] nxt;
    if (h_req && !h_gnt) begin
      nxt = (cnt == limit) ? cnt : cnt + 4'd1;
    end else begin
      nxt = 4'd0;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the MEM stage and a host port.
// MEM stage has priority; a starvation counter forces a host grant periodically.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int DBITS        = DEF_DBITS,
  parameter int ADDRBITS     = DEF_ADDRBITS,
  parameter int DMEMADDRBITS = DEF_DMEMADDRBITS,
  parameter int DMEMWORDBITS = DEF_DMEMWORDBITS,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             p_req_i,
  input  logic                             p_we_i,
  input  logic [ADDRBITS-1:0]              p_addr_i,
  input  logic [DBITS-1:0]                 p_wdata_i,
  output logic                             p_stall_o,
  output logic                             p_rvalid_o,
  output logic [DBITS-1:0]                 p_rdata_o,
  input  logic                             h_req_i,
  input  logic                             h_we_i,
  input  logic [ADDRBITS-1:0]              h_addr_i,
  input  logic [DBITS-1:0]                 h_wdata_i,
  output logic                             h_gnt_o,
  output logic                             h_rvalid_o,
  output logic [DBITS-1:0]                 h_rdata_o,
  output logic                             mem_en_o,
  output logic                             mem_we_o,
  output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_addr_o,
  output logic [DBITS-1:0]                 mem_wdata_o,
  input  logic [DBITS-1:0]                 mem_rdata_i
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  rd_owner_e  rd_owner_q, rd_owner_d;
  logic       p_win_s, h_win_s;
  logic       unused_addr_s;

  // Address bits outside the decoded window are intentionally dropped.
  assign unused_addr_s = ^{p_addr_i[ADDRBITS-1:DMEMADDRBITS], p_addr_i[DMEMWORDBITS-1:0],
                           h_addr_i[ADDRBITS-1:DMEMADDRBITS], h_addr_i[DMEMWORDBITS-1:0]};

  always_comb begin
    p_win_s = 1'b0;
    h_win_s = 1'b0;
    if (reset) begin
      p_win_s = 1'b0;
      h_win_s = 1'b0;
    end else if (h_req_i && (starve_q == STARVE_MAX)) begin
      h_win_s = 1'b1;
    end else if (p_req_i) begin
      p_win_s = 1'b1;
    end else if (h_req_i) begin
      h_win_s = 1'b1;
    end else begin
      p_win_s = 1'b0;
      h_win_s = 1'b0;
    end
  end

  always_comb begin
    mem_en_o    = p_win_s | h_win_s;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (h_win_s) begin
      mem_we_o    = h_we_i;
      mem_addr_o  = h_addr_i[DMEMADDRBITS-1:DMEMWORDBITS];
      mem_wdata_o = h_wdata_i;
    end else if (p_win_s) begin
      mem_we_o    = p_we_i;
      mem_addr_o  = p_addr_i[DMEMADDRBITS-1:DMEMWORDBITS];
      mem_wdata_o = p_wdata_i;
    end else begin
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
    end
  end

  assign p_stall_o = p_req_i & ~p_win_s & ~reset;
  assign h_gnt_o   = h_win_s;
  assign starve_d  = starve_next(starve_q, h_req_i, h_win_s, STARVE_MAX);

  always_comb begin
    rd_owner_d = RD_NONE;
    if (p_win_s && !p_we_i) begin
      rd_owner_d = RD_P;
    end else if (h_win_s && !h_we_i) begin
      rd_owner_d = RD_H;
    end else begin
      rd_owner_d = RD_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q   <= 4'd0;
      rd_owner_q <= RD_NONE;
    end else begin
      starve_q   <= starve_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Reset also masks a read that is already in flight this cycle.
  always_comb begin
    p_rvalid_o = 1'b0;
    h_rvalid_o = 1'b0;
    case (rd_owner_q)
      RD_P:    p_rvalid_o = ~reset;
      RD_H:    h_rvalid_o = ~reset;
      default: begin
        p_rvalid_o = 1'b0;
        h_rvalid_o = 1'b0;
      end
    endcase
  end

  assign p_rdata_o = p_rvalid_o ? mem_rdata_i : '0;
  assign h_rdata_o = h_rvalid_o ? mem_rdata_i : '0;

endmodule
